// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL,
        CLS_RALU,
        CLS_SHIFT,
        CLS_IMM,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_SYSCALL
    } iclass_t;

    localparam logic [1:0] ALUX_REGS = 2'd0;
    localparam logic [1:0] ALUX_REGT = 2'd1;
    localparam logic [1:0] ALUX_PC   = 2'd2;

    localparam logic [2:0] ALUY_REGT  = 3'd0;
    localparam logic [2:0] ALUY_SHAMT = 3'd1;
    localparam logic [2:0] ALUY_SIMM  = 3'd2;
    localparam logic [2:0] ALUY_FOUR  = 3'd3;
    localparam logic [2:0] ALUY_REGS  = 3'd4;
    localparam logic [2:0] ALUY_ZIMM  = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational opcode/funct classifier and EXEC ALU settings
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [1:0] alux,
    output logic [2:0] aluy,
    output logic [3:0] aluop,
    output logic       regdst,
    output logic       illegal
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        alux   = ALUX_REGS;
        aluy   = ALUY_REGT;
        aluop  = ALU_ADD;
        regdst = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regdst = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: begin iclass = CLS_RALU; aluop = ALU_ADD; end
                    FN_SUB, FN_SUBU: begin iclass = CLS_RALU; aluop = ALU_SUB; end
                    FN_AND:          begin iclass = CLS_RALU; aluop = ALU_AND; end
                    FN_OR:           begin iclass = CLS_RALU; aluop = ALU_OR;  end
                    FN_XOR:          begin iclass = CLS_RALU; aluop = ALU_XOR; end
                    FN_NOR:          begin iclass = CLS_RALU; aluop = ALU_NOR; end
                    FN_SLT:          begin iclass = CLS_RALU; aluop = ALU_SLT; end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shifts take the operand from rt and the amount from shamt.
                        iclass = CLS_SHIFT;
                        alux   = ALUX_REGT;
                        aluy   = ALUY_SHAMT;
                        aluop  = (funct == FN_SLL) ? ALU_SLL :
                                 (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    FN_SYSCALL:      iclass = CLS_SYSCALL;
                    default:         iclass = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin iclass = CLS_IMM; aluy = ALUY_SIMM; aluop = ALU_ADD; end
            OP_SLTI:           begin iclass = CLS_IMM; aluy = ALUY_SIMM; aluop = ALU_SLT; end
            OP_ANDI:           begin iclass = CLS_IMM; aluy = ALUY_ZIMM; aluop = ALU_AND; end
            OP_ORI:            begin iclass = CLS_IMM; aluy = ALUY_ZIMM; aluop = ALU_OR;  end
            OP_LW:             begin iclass = CLS_LW;  aluy = ALUY_SIMM; end
            OP_SW:             begin iclass = CLS_SW;  aluy = ALUY_SIMM; end
            OP_BEQ:            begin iclass = CLS_BEQ; aluop = ALU_SUB; end
            OP_BNE:            begin iclass = CLS_BNE; aluop = ALU_SUB; end
            OP_J:              iclass = CLS_J;
            default:           iclass = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (iclass == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset control FSM with memory timeout and retire counter
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] instr,
    input  logic        memReady,
    input  logic        aluZero,
    output logic [1:0]  aluX,
    output logic [2:0]  aluY,
    output logic [3:0]  aluOp,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        irWrite,
    output logic        memReq,
    output logic        memWrite,
    output logic        regWrite,
    output logic        regDst,
    output logic        memToReg,
    output logic [31:0] instrCount,
    output logic        halted,
    output logic        busErr,
    output logic        illegal
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, nstate;
    logic [7:0] waitcnt;
    logic       buserr_q, illegal_q;
    logic       retire, set_buserr, set_illegal, wait_hit;

    iclass_t    dec_class;
    logic [1:0] dec_alux;
    logic [2:0] dec_aluy;
    logic [3:0] dec_aluop;
    logic       dec_regdst, dec_illegal;
    logic       unused_instr;

    assign unused_instr = ^instr[25:6];

    multicycle_ctrl_decode u_decode (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .iclass  (dec_class),
        .alux    (dec_alux),
        .aluy    (dec_aluy),
        .aluop   (dec_aluop),
        .regdst  (dec_regdst),
        .illegal (dec_illegal)
    );

    // The last allowed wait cycle still accepts memReady; only its absence trips the error.
    assign wait_hit = (waitcnt == WAIT_LAST);

    always_comb begin
        nstate      = state;
        retire      = 1'b0;
        set_buserr  = 1'b0;
        set_illegal = 1'b0;
        aluX        = ALUX_REGS;
        aluY        = ALUY_REGT;
        aluOp       = ALU_ADD;
        pcWrite     = 1'b0;
        pcSrc       = PCSRC_ALU;
        irWrite     = 1'b0;
        memReq      = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        case (state)
            ST_IDLE: nstate = ST_FETCH;
            ST_FETCH: begin
                memReq = 1'b1;
                aluX   = ALUX_PC;
                aluY   = ALUY_FOUR;
                aluOp  = ALU_ADD;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    nstate  = ST_DECODE;
                end else if (wait_hit) begin
                    set_buserr = 1'b1;
                    nstate     = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    set_illegal = 1'b1;
                    nstate      = ST_HALT;
                end else if (dec_class == CLS_SYSCALL) begin
                    retire = 1'b1;
                    nstate = ST_HALT;
                end else begin
                    nstate = ST_EXEC;
                end
            end
            ST_EXEC: begin
                aluX  = dec_alux;
                aluY  = dec_aluy;
                aluOp = dec_aluop;
                case (dec_class)
                    CLS_RALU, CLS_SHIFT, CLS_IMM: nstate = ST_WB;
                    CLS_LW, CLS_SW:               nstate = ST_MEM;
                    CLS_BEQ, CLS_BNE: begin
                        if (aluZero == (dec_class == CLS_BEQ)) begin
                            pcWrite = 1'b1;
                            pcSrc   = PCSRC_BRANCH;
                        end
                        retire = 1'b1;
                        nstate = ST_FETCH;
                    end
                    CLS_J: begin
                        pcWrite = 1'b1;
                        pcSrc   = PCSRC_JUMP;
                        retire  = 1'b1;
                        nstate  = ST_FETCH;
                    end
                    default: nstate = ST_HALT;
                endcase
            end
            ST_MEM: begin
                memReq   = 1'b1;
                memWrite = (dec_class == CLS_SW);
                if (memReady) begin
                    if (dec_class == CLS_SW) begin
                        retire = 1'b1;
                        nstate = ST_FETCH;
                    end else begin
                        nstate = ST_WB;
                    end
                end else if (wait_hit) begin
                    set_buserr = 1'b1;
                    nstate     = ST_HALT;
                end
            end
            ST_WB: begin
                regWrite = 1'b1;
                regDst   = dec_regdst;
                memToReg = (dec_class == CLS_LW);
                retire   = 1'b1;
                nstate   = ST_FETCH;
            end
            default: nstate = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= ST_IDLE;
            waitcnt    <= 8'd0;
            instrCount <= 32'd0;
            buserr_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state <= nstate;
            // Counts only while a memory phase keeps waiting; any state change restarts it.
            if ((state == ST_FETCH || state == ST_MEM) && nstate == state)
                waitcnt <= waitcnt + 8'd1;
            else
                waitcnt <= 8'd0;
            if (retire)
                instrCount <= instrCount + 32'd1;
            if (set_buserr)
                buserr_q <= 1'b1;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    assign halted  = (state == ST_HALT);
    assign busErr  = buserr_q;
    assign illegal = illegal_q;

endmodule
